v74x148_seq: RTL and testbench

//  Sequential 8-to-3 priority encoder, the encoding counterpart of the lab's 2-to-4 decoders.
//  - Active-low request lines are latched as sticky pending bits.
//  - The highest-priority pending index is presented as an active-low code, with 74x148-style
//    GS_L/EO_L cascade pins.
//  - The code is held stable until the consumer acknowledges it.
//  - Sits between decoder-driven request lines and a downstream service unit.

---
 rtl/v74x148_seq_pkg.sv | 11 +
 rtl/v74x148_seq_if.sv | 24 ++
 rtl/v74x148_prio.sv | 20 ++
 rtl/v74x148_seq.sv | 72 +++++++
 tb/tb_v74x148_seq.sv | 122 ++++++++++++
 5 files changed

// File: rtl/v74x148_seq_pkg.sv
// rtl/v74x148_seq_pkg.sv - shared state encoding and default width for the sequential 74x148
package v74x148_seq_pkg;

  localparam int W_DEFAULT = 3;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/v74x148_seq_if.sv
// rtl/v74x148_seq_if.sv - request/acknowledge bus of the sequential priority encoder
interface v74x148_seq_if #(
  parameter int W = 3
);
  localparam int N = 1 << W;

  logic         ei_l;
  logic [N-1:0] i_l;
  logic         ack;
  logic [W-1:0] a_l;
  logic         gs_l;
  logic         eo_l;
  logic [N-1:0] pend;

  modport master (
    output ei_l, i_l, ack,
    input  a_l, gs_l, eo_l, pend
  );

  modport slave (
    input  ei_l, i_l, ack,
    output a_l, gs_l, eo_l, pend
  );
endinterface

// File: rtl/v74x148_prio.sv
// rtl/v74x148_prio.sv - combinational highest-set-bit encoder with any-bit flag
module v74x148_prio #(
  parameter int W = 3
) (
  input  logic [(1<<W)-1:0] x,
  output logic [W-1:0]      idx,
  output logic              any
);
  localparam int N = 1 << W;

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) idx = W'(i);
    end
  end

  assign any = |x;
endmodule

// File: rtl/v74x148_seq.sv
// rtl/v74x148_seq.sv - sticky-request 8-to-3 priority encoder holding each code until acknowledged
module v74x148_seq
  import v74x148_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  v74x148_seq_if.slave      bus
);
  localparam int N = 1 << W;

  state_t       state;
  logic [W-1:0] code;
  logic [N-1:0] pend;

  logic [N-1:0] cap;
  logic [N-1:0] clr;
  logic [N-1:0] pend_nxt;
  logic [N-1:0] prio_in;
  logic [W-1:0] prio_idx;
  logic         prio_any;
  logic         ack_ok;

  assign ack_ok   = (state == S_SERVE) && bus.ack;
  assign cap      = bus.ei_l ? '0 : ~bus.i_l;
  assign clr      = ack_ok ? (N'(1) << code) : '0;
  // A bit acked and re-requested in the same cycle must survive, so capture is OR-ed after the clear.
  assign pend_nxt = (pend & ~clr) | cap;

  // IDLE looks only at already-registered bits; SERVE hands off on the post-ack vector.
  assign prio_in  = (state == S_SERVE) ? pend_nxt : pend;

  v74x148_prio #(.W(W)) u_prio (
    .x   (prio_in),
    .idx (prio_idx),
    .any (prio_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pend  <= '0;
      state <= S_IDLE;
      code  <= '0;
    end else begin
      pend <= pend_nxt;
      case (state)
        S_IDLE: begin
          if (prio_any) begin
            state <= S_SERVE;
            code  <= prio_idx;
          end
        end
        S_SERVE: begin
          if (bus.ack) begin
            if (prio_any) begin
              code <= prio_idx;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.a_l  = (state == S_SERVE) ? ~code : '1;
  assign bus.gs_l = (state != S_SERVE);
  assign bus.eo_l = ~(~reset & ~bus.ei_l & (pend == '0) & (&bus.i_l) & (state == S_IDLE));
  assign bus.pend = pend;
endmodule

// File: tb/tb_v74x148_seq.sv
// tb/tb_v74x148_seq.sv - directed-vector bench for the sequential priority encoder
module tb_v74x148_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  v74x148_seq_if #(.W(3)) bus ();

  v74x148_seq #(.W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    bus.ei_l = 1'b0;
    bus.i_l  = 8'h00;
    bus.ack  = 1'b0;

    // 1: reset
    tick(); tick();
    check("rst_pend", bus.pend, 8'h00);
    check("rst_a_l",  8'(bus.a_l), 8'h07);
    check("rst_gs_l", 8'(bus.gs_l), 8'h01);
    check("rst_eo_l", 8'(bus.eo_l), 8'h01);
    reset   = 1'b0;
    bus.i_l = 8'hFF;
    #1;
    check("idle_eo_l", 8'(bus.eo_l), 8'h00);
    tick();
    check("idle_eo_l_edge", 8'(bus.eo_l), 8'h00);

    // 2: single request bit2
    bus.i_l = 8'hFB; tick(); bus.i_l = 8'hFF;
    check("t2_pend", bus.pend, 8'h04);
    check("t2_gs_early", 8'(bus.gs_l), 8'h01);
    check("t2_eo_pend", 8'(bus.eo_l), 8'h01);
    tick();
    check("t2_gs", 8'(bus.gs_l), 8'h00);
    check("t2_a_l", 8'(bus.a_l), 8'h05);
    tick();
    check("t2_hold", 8'(bus.a_l), 8'h05);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("t2_ack_gs", 8'(bus.gs_l), 8'h01);
    check("t2_ack_pend", bus.pend, 8'h00);
    check("t2_ack_a_l", 8'(bus.a_l), 8'h07);

    // 3: bits 4 and 2, back-to-back
    bus.i_l = 8'hEB; tick(); bus.i_l = 8'hFF; tick();
    check("t3_a_l4", 8'(bus.a_l), 8'h03);
    bus.ack = 1'b1; tick();
    check("t3_a_l2", 8'(bus.a_l), 8'h05);
    check("t3_gs_nobubble", 8'(bus.gs_l), 8'h00);
    tick(); bus.ack = 1'b0;
    check("t3_idle_gs", 8'(bus.gs_l), 8'h01);
    check("t3_idle_pend", bus.pend, 8'h00);

    // 4: no preemption by bit7
    bus.i_l = 8'hFB; tick(); bus.i_l = 8'hFF; tick();
    check("t4_a_l2", 8'(bus.a_l), 8'h05);
    bus.i_l = 8'h7F; tick(); bus.i_l = 8'hFF;
    check("t4_pend", bus.pend, 8'h84);
    check("t4_nopreempt", 8'(bus.a_l), 8'h05);
    tick();
    check("t4_hold", 8'(bus.a_l), 8'h05);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("t4_a_l7", 8'(bus.a_l), 8'h00);
    check("t4_pend7", bus.pend, 8'h80);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("t4_idle_gs", 8'(bus.gs_l), 8'h01);

    // 5: set wins over ack clear
    bus.i_l = 8'hF7; tick(); bus.i_l = 8'hFF; tick();
    check("t5_a_l3", 8'(bus.a_l), 8'h04);
    bus.ack = 1'b1; bus.i_l = 8'hF7; tick(); bus.ack = 1'b0; bus.i_l = 8'hFF;
    check("t5_pend_kept", bus.pend, 8'h08);
    check("t5_gs", 8'(bus.gs_l), 8'h00);
    check("t5_a_l3_again", 8'(bus.a_l), 8'h04);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("t5_idle_gs", 8'(bus.gs_l), 8'h01);
    check("t5_idle_pend", bus.pend, 8'h00);

    // 6: disabled input, then reset mid-SERVE
    bus.ei_l = 1'b1; bus.i_l = 8'h00;
    #1;
    check("t6_eo_dis", 8'(bus.eo_l), 8'h01);
    tick();
    check("t6_pend_dis", bus.pend, 8'h00);
    check("t6_gs_dis", 8'(bus.gs_l), 8'h01);
    check("t6_eo_dis_edge", 8'(bus.eo_l), 8'h01);
    bus.ei_l = 1'b0; bus.i_l = 8'hFD; tick(); bus.i_l = 8'hFF; tick();
    check("t6_a_l1", 8'(bus.a_l), 8'h06);
    bus.i_l = 8'h7F; tick(); bus.i_l = 8'hFF;
    check("t6_pend_pre", bus.pend, 8'h82);
    reset = 1'b1; tick();
    check("t6_rst_pend", bus.pend, 8'h00);
    check("t6_rst_a_l", 8'(bus.a_l), 8'h07);
    check("t6_rst_gs", 8'(bus.gs_l), 8'h01);
    check("t6_rst_eo", 8'(bus.eo_l), 8'h01);
    reset = 1'b0; tick();
    check("t6_post_eo", 8'(bus.eo_l), 8'h00);
    check("t6_post_gs", 8'(bus.gs_l), 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
